// File: rtl/bf_pkg.sv
// Shared opcode/state types for the fetch controller and its loop-return stack.
package bf_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpOut  = 3'b001,
    OpBack = 3'b010,
    OpIf   = 3'b011,
    OpMovl = 3'b100,
    OpMovr = 3'b101,
    OpDec  = 3'b110,
    OpInc  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StSkip,
    StHalt
  } state_e;

  // Brackets are resolved locally; everything else goes to the executor.
  function automatic logic is_data_op(opcode_e code);
    return !(code inside {OpIf, OpBack});
  endfunction

endpackage

// File: rtl/bf_fetch_ctrl_if.sv
// ROM fetch port and executor op handshake, grouped as one bus.
interface bf_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_code;
  logic              rom_overrun;
  logic              op_valid;
  logic [2:0]        op;
  logic              op_ready;
  logic              exec_idle;
  logic              cell_zero;

  modport master (
    output rom_addr, op_valid, op,
    input  rom_code, rom_overrun, op_ready, exec_idle, cell_zero
  );

  modport slave (
    input  rom_addr, op_valid, op,
    output rom_code, rom_overrun, op_ready, exec_idle, cell_zero
  );
endinterface

// File: rtl/bf_loop_stack.sv
// LIFO of loop-open addresses; top is only meaningful while not empty.
module bf_loop_stack #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SpW-1:0]    sp_q, sp_d, sp_m1;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic              do_push, do_pop;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SpW'(STACK_DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign sp_m1   = sp_q - SpW'(1);
  assign top     = mem_q[sp_m1[IdxW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (do_push) begin
      sp_d = sp_q + SpW'(1);
    end else if (do_pop) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries need no reset: they are never read while the stack is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[sp_q[IdxW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/bf_fetch_ctrl.sv
// Program counter and control-flow stage: issues data ops to the executor and
// resolves loops locally with a return stack and a forward bracket-skip scan.
module bf_fetch_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned SKIP_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  bf_fetch_ctrl_if.master  bus,
  output logic             halted,
  output logic             error
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              over_q, over_d;
  logic [SKIP_W-1:0] depth_q, depth_d;
  logic              error_q, error_d;
  logic              halted_q, halted_d;

  logic              stk_clear, stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty, stk_full;

  opcode_e           code;
  logic              at_end;
  logic [ADDR_W:0]   pc_inc;

  assign code   = opcode_e'(bus.rom_code);
  // over_q marks a PC that carried out of the top address; it reads as overrun.
  assign at_end = bus.rom_overrun || over_q;
  assign pc_inc = {1'b0, pc_q} + (ADDR_W + 1)'(1);

  assign bus.rom_addr = pc_q;
  assign bus.op_valid = (state_q == StExec) && !at_end && is_data_op(code);
  assign bus.op       = bus.op_valid ? bus.rom_code : OpNop;
  assign halted       = halted_q;
  assign error        = error_q;

  bf_loop_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_loop_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    over_d    = over_q;
    depth_d   = depth_q;
    error_d   = error_q;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d   = StExec;
          pc_d      = '0;
          over_d    = 1'b0;
          depth_d   = '0;
          error_d   = 1'b0;
          stk_clear = 1'b1;
        end
      end

      StExec: begin
        if (at_end) begin
          state_d = run ? StHalt : StIdle;
          if (run && !stk_empty) begin
            error_d = 1'b1;
          end
        end else if (is_data_op(code)) begin
          // An op once presented stays until accepted, even when aborting.
          if (bus.op_ready) begin
            {over_d, pc_d} = pc_inc;
            if (!run) begin
              state_d = StIdle;
            end
          end
        end else if (!run) begin
          state_d = StIdle;
        end else if (bus.exec_idle) begin
          if (code == OpIf) begin
            if (bus.cell_zero) begin
              state_d        = StSkip;
              depth_d        = SKIP_W'(1);
              {over_d, pc_d} = pc_inc;
            end else if (stk_full) begin
              state_d = StHalt;
              error_d = 1'b1;
            end else begin
              stk_push       = 1'b1;
              {over_d, pc_d} = pc_inc;
            end
          end else begin
            if (stk_empty) begin
              state_d = StHalt;
              error_d = 1'b1;
            end else if (bus.cell_zero) begin
              stk_pop        = 1'b1;
              {over_d, pc_d} = pc_inc;
            end else begin
              pc_d   = stk_top + ADDR_W'(1);
              over_d = 1'b0;
            end
          end
        end
      end

      StSkip: begin
        if (!run) begin
          state_d = StIdle;
        end else if (at_end) begin
          state_d = StHalt;
          error_d = 1'b1;
        end else begin
          {over_d, pc_d} = pc_inc;
          if (code == OpIf) begin
            if (depth_q == '1) begin
              state_d = StHalt;
              error_d = 1'b1;
            end else begin
              depth_d = depth_q + SKIP_W'(1);
            end
          end else if (code == OpBack) begin
            depth_d = depth_q - SKIP_W'(1);
            if (depth_q == SKIP_W'(1)) begin
              state_d = StExec;
            end
          end
        end
      end

      StHalt: begin
        if (!run) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      over_q   <= 1'b0;
      depth_q  <= '0;
      error_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      over_q   <= over_d;
      depth_q  <= depth_d;
      error_q  <= error_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_bf_fetch_ctrl.sv
// Directed bench for bf_fetch_ctrl with a behavioural ROM and executor.
module tb_bf_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic halted, error;

  logic       op_ready;
  logic       track;
  logic       cz_force;
  int         cell_base;
  int         net;
  int         net0;
  int         prog_len;
  logic [2:0] rom [256];

  int errors = 0;
  int checks = 0;

  int         addr_q [$];
  logic [2:0] op_q   [$];

  bf_fetch_ctrl_if #(.ADDR_W(8)) bus ();

  bf_fetch_ctrl #(
    .ADDR_W      (8),
    .STACK_DEPTH (16),
    .SKIP_W      (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .halted (halted),
    .error  (error)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.rom_overrun = (int'(bus.rom_addr) >= prog_len);
    bus.rom_code    = bus.rom_overrun ? 3'b000 : rom[bus.rom_addr];
    bus.op_ready    = op_ready;
    bus.exec_idle   = 1'b1;
    bus.cell_zero   = track ? ((cell_base + net - net0) == 0) : cz_force;
  end

  // Executor model: net tracks INC/DEC accepted since reset.
  initial net = 0;
  always @(posedge clk) begin
    if (bus.op_valid && bus.op_ready) begin
      if (bus.op == 3'b111) net <= net + 1;
      else if (bus.op == 3'b110) net <= net - 1;
    end
  end

  function automatic logic [2:0] enc(input byte c);
    case (c)
      "+": return 3'b111;
      "-": return 3'b110;
      ">": return 3'b101;
      "<": return 3'b100;
      "[": return 3'b011;
      "]": return 3'b010;
      ".": return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic load(input string s);
    prog_len = s.len();
    for (int i = 0; i < s.len(); i++) rom[i] = enc(s[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop run to reach IDLE, then raise it; returns with pc=0 in EXEC.
  task automatic go();
    run = 1'b0;
    tick();
    net0 = net;
    run = 1'b1;
    tick();
  endtask

  task automatic capture(input int max_cyc);
    addr_q.delete();
    op_q.delete();
    for (int i = 0; i < max_cyc && !halted; i++) begin
      addr_q.push_back(int'(bus.rom_addr));
      if (bus.op_valid && bus.op_ready) op_q.push_back(bus.op);
      tick();
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("FAIL reset rom_addr: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset op_valid: got %0b want 0", bus.op_valid); end
    checks++; if (bus.op !== 3'b000) begin errors++; $display("FAIL reset op: got %0d want 0", bus.op); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset halted: got %0b want 0", halted); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset error: got %0b want 0", error); end
  endtask

  task automatic test_straight();
    int         exp_addr [5] = '{0, 1, 2, 3, 4};
    logic [2:0] exp_op   [4] = '{3'b111, 3'b111, 3'b111, 3'b001};
    load("+++.");
    op_ready = 1'b1; track = 1'b1; cell_base = 0;
    go();
    capture(20);
    checks++; if (addr_q.size() != 5) begin errors++; $display("FAIL straight cycles: got %0d want 5", addr_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (addr_q[i] != exp_addr[i]) begin errors++; $display("FAIL straight addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]); end
    end
    checks++; if (op_q.size() != 4) begin errors++; $display("FAIL straight op count: got %0d want 4", op_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_q[i] !== exp_op[i]) begin errors++; $display("FAIL straight op[%0d]: got %0d want %0d", i, op_q[i], exp_op[i]); end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL straight halted: got %0b want 1", halted); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL straight error: got %0b want 0", error); end
  endtask

  task automatic test_loop();
    int         exp_addr [7] = '{0, 1, 2, 3, 2, 3, 4};
    logic [2:0] exp_op   [3] = '{3'b111, 3'b110, 3'b110};
    load("+[-]");
    op_ready = 1'b1; track = 1'b1; cell_base = 1;
    go();
    capture(30);
    checks++; if (addr_q.size() != 7) begin errors++; $display("FAIL loop cycles: got %0d want 7", addr_q.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (addr_q[i] != exp_addr[i]) begin errors++; $display("FAIL loop addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]); end
    end
    checks++; if (op_q.size() != 3) begin errors++; $display("FAIL loop op count: got %0d want 3", op_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (op_q[i] !== exp_op[i]) begin errors++; $display("FAIL loop op[%0d]: got %0d want %0d", i, op_q[i], exp_op[i]); end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL loop error: got %0b want 0", error); end
  endtask

  task automatic test_skip();
    load("[+[+]+].");
    op_ready = 1'b1; track = 1'b0; cz_force = 1'b1;
    go();
    capture(30);
    checks++; if (addr_q.size() != 9) begin errors++; $display("FAIL skip cycles: got %0d want 9", addr_q.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (addr_q[i] != i) begin errors++; $display("FAIL skip addr[%0d]: got %0d want %0d", i, addr_q[i], i); end
    end
    checks++; if (op_q.size() != 1) begin errors++; $display("FAIL skip op count: got %0d want 1", op_q.size()); end
    checks++; if (op_q[0] !== 3'b001) begin errors++; $display("FAIL skip first op: got %0d want 1", op_q[0]); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL skip error: got %0b want 0", error); end
  endtask

  task automatic test_stall();
    load("+.");
    op_ready = 1'b0; track = 1'b1; cell_base = 0;
    go();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL stall op_valid[%0d]: got %0b want 1", i, bus.op_valid); end
      checks++; if (bus.op !== 3'b111) begin errors++; $display("FAIL stall op[%0d]: got %0d want 7", i, bus.op); end
      checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("FAIL stall pc[%0d]: got %0d want 0", i, bus.rom_addr); end
      tick();
    end
    op_ready = 1'b1;
    checks++; if (bus.op !== 3'b111) begin errors++; $display("FAIL stall op at accept: got %0d want 7", bus.op); end
    tick();
    checks++; if (bus.rom_addr !== 8'd1) begin errors++; $display("FAIL stall pc after accept: got %0d want 1", bus.rom_addr); end
    checks++; if (bus.op !== 3'b001) begin errors++; $display("FAIL stall next op: got %0d want 1", bus.op); end
    capture(10);
  endtask

  task automatic test_errors();
    load("]");
    op_ready = 1'b1; track = 1'b0; cz_force = 1'b0;
    go();
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL underflow halted: got %0b want 1", halted); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL underflow error: got %0b want 1", error); end
    load("[[[[[[[[[[[[[[[[[");
    go();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL error cleared on start: got %0b want 0", error); end
    capture(40);
    checks++; if (addr_q.size() != 17) begin errors++; $display("FAIL overflow cycles: got %0d want 17", addr_q.size()); end
    checks++; if (bus.rom_addr !== 8'd16) begin errors++; $display("FAIL overflow pc: got %0d want 16", bus.rom_addr); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL overflow error: got %0b want 1", error); end
    load("[");
    go();
    capture(10);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL open loop at end error: got %0b want 1", error); end
    load("[[");
    cz_force = 1'b1;
    go();
    capture(10);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL overrun in skip error: got %0b want 1", error); end
  endtask

  task automatic test_abort();
    load("++");
    op_ready = 1'b0; track = 1'b1; cell_base = 0;
    go();
    run = 1'b0;
    tick();
    checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL abort pending op_valid: got %0b want 1", bus.op_valid); end
    op_ready = 1'b1;
    tick();
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL abort idle op_valid: got %0b want 0", bus.op_valid); end
    checks++; if (bus.rom_addr !== 8'd1) begin errors++; $display("FAIL abort pc: got %0d want 1", bus.rom_addr); end
    tick();
    checks++; if (halted !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL abort flags: got %0b%0b want 00", halted, error); end
  endtask

  task automatic test_reset_mid();
    load("[++++++]");
    op_ready = 1'b1; track = 1'b0; cz_force = 1'b1;
    go();
    tick();
    tick();
    checks++; if (bus.rom_addr !== 8'd2) begin errors++; $display("FAIL mid-skip pc: got %0d want 2", bus.rom_addr); end
    rst_n = 1'b0;
    #1;
    test_reset();
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    load("]");
    go();
    tick();
    load("+.");
    op_ready = 1'b0; track = 1'b1; cell_base = 0;
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL mid-handshake op_valid: got %0b want 1", bus.op_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset drops op_valid: got %0b want 0", bus.op_valid); end
    checks++; if (bus.op !== 3'b000) begin errors++; $display("FAIL reset op: got %0d want 0", bus.op); end
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    op_ready = 1'b1;
    go();
    checks++; if (bus.rom_addr !== 8'd0) begin errors++; $display("FAIL restart pc: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.op !== 3'b111) begin errors++; $display("FAIL restart op: got %0d want 7", bus.op); end
    capture(10);
    checks++; if (op_q.size() != 2) begin errors++; $display("FAIL restart op count: got %0d want 2", op_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; op_ready = 1'b1; track = 1'b1; cz_force = 1'b0;
    cell_base = 0; net0 = 0; prog_len = 0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_straight();
    test_loop();
    test_skip();
    test_stall();
    test_errors();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
